seq_detect_param: RTL and testbench
===================================

SEQ_DETECT_PARAM -- requirements
Module: seq_detect_param

Interface
REQ-001 The block SHALL have parameter MAX_LEN, default 8: maximum pattern length in bits, legal range 2..16.
REQ-002 The block SHALL have parameter CNT_W, default 8: width of the match counter.
REQ-003 The block SHALL have parameter DEF_PATTERN, default 8'b0000_0101: pattern after reset, MAX_LEN bits wide.
REQ-004 The block SHALL have parameter DEF_LEN, default 3: pattern length after reset.
REQ-005 The block SHALL have parameter DEF_OVERLAP, default 1: overlap mode after reset.
REQ-006 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-007 The block SHALL have port rst, input, 1 bit: reset, synchronous and active-low.
REQ-008 The block SHALL have port in, input, 1 bit: serial data bit, sampled when en=1.
REQ-009 The block SHALL have port en, input, 1 bit: sample enable.
REQ-010 The block SHALL have port cfg_load, input, 1 bit: configuration load strobe.
REQ-011 The block SHALL have port cfg_pattern, input, MAX_LEN bits: new pattern.
REQ-012 The block SHALL have port cfg_len, input, $clog2(MAX_LEN)+1 bits: new pattern length.
REQ-013 The block SHALL have port cfg_overlap, input, 1 bit: new mode; 1 = overlapping matches, 0 = non-overlapping.
REQ-014 The block SHALL have port out, output, 1 bit: registered match pulse.
REQ-015 The block SHALL have port match_count, output, CNT_W bits: saturating count of matches.
REQ-016 The block SHALL have port armed, output, 1 bit: 1 when the FSM is in ARMED.

Function
REQ-017 The block SHALL match when the last L sampled bits equal cfg pattern bits [L-1:0], where L is the active length; pattern bit L-1 is the earliest bit received and bit 0 is the latest.
REQ-018 Loaded lengths SHALL be clamped: values below 2 become 2 and values above MAX_LEN become MAX_LEN.
REQ-019 The FSM SHALL have states EMPTY (fill=0), FILLING (0<fill<L) and ARMED (fill=L), where fill counts valid history bits.
REQ-020 On an edge with en=1 and cfg_load=0, the block SHALL shift in into the history LSB and increment fill, saturating at L.
- EMPTY goes to FILLING.
- FILLING goes to ARMED when fill reaches L.
REQ-021 out SHALL be 1 for exactly one cycle, starting at the edge that samples the completing bit (latency 1 edge from that bit being presented), and 0 otherwise.
REQ-022 On a match in overlap mode, fill SHALL remain L and the FSM SHALL stay in ARMED.
REQ-023 On a match in non-overlap mode, fill and history SHALL clear and the FSM SHALL go to EMPTY, so the next match needs L fresh bits.
REQ-024 On each match, match_count SHALL increment, holding at 2^CNT_W-1 once saturated.
REQ-025 With en=0, history, fill and state SHALL hold and out SHALL be 0.
REQ-026 On an edge with cfg_load=1, the block SHALL:
- latch the pattern, the clamped length and the mode;
- clear history and fill and go to EMPTY;
- force out=0 and leave match_count unchanged;
- ignore in and en on that edge (cfg_load has priority over sampling).
REQ-027 Pattern bits above L-1 SHALL be ignored in the compare.

Reset
REQ-028 On an edge with rst=0, the block SHALL set out=0, match_count=0, armed=0, history=0, fill=0 and state EMPTY, and load pattern/length/mode from DEF_PATTERN/DEF_LEN/DEF_OVERLAP; reset has priority over cfg_load and en.
REQ-029 Reset asserted mid-sequence SHALL discard partial history, so a match requires L new bits after release.

Verification
REQ-030 Defaults (101, L=3, overlap), en=1, in=1,0,1,0,1 -> out pulses after the 3rd and 5th bits; match_count=2.
REQ-031 Load pattern 101, len 3, cfg_overlap=0, in=1,0,1,0,1 -> single pulse after the 3rd bit; match_count=1.
REQ-032 Load pattern 0000, len 4, overlap; in=0,0,0,0,0,1,0 -> pulses after the 4th and 5th bits; count=2; armed drops to 0 only on a cfg_load or reset.
REQ-033 Defaults, in=1,0; rst=0 for one cycle; then in=1 -> no pulse; then in=0,1 -> one pulse.
REQ-034 Defaults, in=1,0, en=0 for 3 cycles (in toggling), en=1 with in=1 -> pulse on that edge only; out=0 while en=0.
REQ-035 CNT_W=2, overlap pattern 11 with L=2, in=1 for 6 cycles -> 5 pulses; match_count sticks at 3.

Source files
------------

// File: rtl/seq_detect_param.sv
// seq_detect_param: runtime-configurable serial pattern detector with overlap mode and saturating match count
module seq_detect_param #(
  parameter int                 MAX_LEN     = 8,
  parameter int                 CNT_W       = 8,
  parameter logic [MAX_LEN-1:0] DEF_PATTERN = 8'b0000_0101,
  parameter int                 DEF_LEN     = 3,
  parameter bit                 DEF_OVERLAP = 1'b1,
  localparam int                LW          = $clog2(MAX_LEN) + 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in,
  input  logic               en,
  input  logic               cfg_load,
  input  logic [MAX_LEN-1:0] cfg_pattern,
  input  logic [LW-1:0]      cfg_len,
  input  logic               cfg_overlap,
  output logic               out,
  output logic [CNT_W-1:0]   match_count,
  output logic               armed
);
  typedef enum logic [1:0] {EMPTY, FILLING, ARMED} state_t;
  state_t state, state_n;
  logic [MAX_LEN-1:0] hist, hist_n, pat, pat_n, mask, shifted;
  logic [LW-1:0] fill, fill_n, len, len_n, fill_inc;
  logic ovl, ovl_n, out_n, hit;
  logic [CNT_W-1:0] match_count_n;
  function automatic logic [LW-1:0] clamp(input logic [LW-1:0] v);
    return v < LW'(2) ? LW'(2) : v > LW'(MAX_LEN) ? LW'(MAX_LEN) : v;
  endfunction
  assign armed = state == ARMED;
  always_comb begin
    shifted = {hist[MAX_LEN-2:0], in};
    mask = {MAX_LEN{1'b1}} >> (LW'(MAX_LEN) - len);
    fill_inc = fill == len ? len : fill + 1'b1;
    hit = fill_inc == len && ((shifted ^ pat) & mask) == '0;
    state_n = state;
    hist_n = hist;
    fill_n = fill;
    pat_n = pat;
    len_n = len;
    ovl_n = ovl;
    out_n = 1'b0;
    match_count_n = match_count;
    if (cfg_load) begin
      pat_n = cfg_pattern;
      len_n = clamp(cfg_len);
      ovl_n = cfg_overlap;
      hist_n = '0;
      fill_n = '0;
      state_n = EMPTY;
    end else if (en) begin
      out_n = hit;
      match_count_n = hit && match_count != '1 ? match_count + 1'b1 : match_count;
      // non-overlap restarts from scratch so the next match needs L fresh bits
      hist_n = hit && !ovl ? '0 : shifted;
      fill_n = hit && !ovl ? '0 : fill_inc;
      state_n = hit && !ovl ? EMPTY : fill_inc == len ? ARMED : FILLING;
    end
  end
  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= EMPTY;
      hist <= '0;
      fill <= '0;
      pat <= DEF_PATTERN;
      len <= clamp(LW'(DEF_LEN));
      ovl <= DEF_OVERLAP;
      out <= 1'b0;
      match_count <= '0;
    end else begin
      state <= state_n;
      hist <= hist_n;
      fill <= fill_n;
      pat <= pat_n;
      len <= len_n;
      ovl <= ovl_n;
      out <= out_n;
      match_count <= match_count_n;
    end
  end
endmodule

// File: tb/tb_seq_detect_param.sv
// tb_seq_detect_param: directed checks of the serial pattern detector, plus a narrow-counter instance for saturation
module tb_seq_detect_param;
  logic clk = 1'b0, rst = 1'b0, in = 1'b0, en = 1'b0, cfg_load = 1'b0, cfg_overlap = 1'b0;
  logic [7:0] cfg_pattern = '0;
  logic [3:0] cfg_len = '0;
  logic out, armed, out_s, armed_s;
  logic [7:0] match_count;
  logic [1:0] cnt_s;
  int n_cmp = 0, n_fail = 0, pulses;
  always #5 clk = ~clk;
  seq_detect_param dut (
    .clk(clk), .rst(rst), .in(in), .en(en), .cfg_load(cfg_load), .cfg_pattern(cfg_pattern),
    .cfg_len(cfg_len), .cfg_overlap(cfg_overlap), .out(out), .match_count(match_count), .armed(armed)
  );
  seq_detect_param #(.CNT_W(2)) dut_s (
    .clk(clk), .rst(rst), .in(in), .en(en), .cfg_load(cfg_load), .cfg_pattern(cfg_pattern),
    .cfg_len(cfg_len), .cfg_overlap(cfg_overlap), .out(out_s), .match_count(cnt_s), .armed(armed_s)
  );
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
    end
  endtask
  task automatic step(input logic b, input logic e);
    in = b;
    en = e;
    @(posedge clk);
    #1;
  endtask
  task automatic do_reset();
    rst = 1'b0;
    step(1'b1, 1'b1);
    rst = 1'b1;
  endtask
  task automatic load(input logic [7:0] p, input logic [3:0] l, input logic o);
    cfg_load = 1'b1;
    cfg_pattern = p;
    cfg_len = l;
    cfg_overlap = o;
    step(1'b1, 1'b1);
    cfg_load = 1'b0;
    chk("load_out", out, 0);
    chk("load_armed", armed, 0);
  endtask
  // bits and exp_out are listed first-sample-first from bit n-1 down to bit 0
  task automatic seq(input string tag, input int n, input logic [15:0] bits, input logic [15:0] exp_out);
    for (int i = n - 1; i >= 0; i--) begin
      step(bits[i], 1'b1);
      chk($sformatf("%s_out%0d", tag, n - i), out, exp_out[i]);
    end
  endtask
  initial begin
    do_reset();
    chk("rst_out", out, 0);
    chk("rst_cnt", match_count, 0);
    chk("rst_armed", armed, 0);
    seq("t030", 5, 16'b10101, 16'b00101);
    chk("t030_cnt", match_count, 2);
    chk("t030_armed", armed, 1);
    do_reset();
    load(8'b101, 4'd3, 1'b0);
    chk("t031_load_cnt", match_count, 0);
    seq("t031", 5, 16'b10101, 16'b00100);
    chk("t031_cnt", match_count, 1);
    chk("t031_armed", armed, 0);
    load(8'b1010_0110, 4'd1, 1'b1);
    seq("clamp_lo", 4, 16'b1010, 16'b0101);
    load(8'hA5, 4'd15, 1'b1);
    seq("clamp_hi", 8, 16'b1010_0101, 16'b0000_0001);
    do_reset();
    load(8'b0000, 4'd4, 1'b1);
    seq("t032", 7, 16'b0000010, 16'b0001100);
    chk("t032_cnt", match_count, 2);
    chk("t032_armed", armed, 1);
    do_reset();
    seq("t033a", 2, 16'b10, 16'b00);
    rst = 1'b0;
    cfg_load = 1'b1;
    cfg_pattern = 8'h00;
    cfg_len = 4'd2;
    step(1'b1, 1'b1);
    rst = 1'b1;
    cfg_load = 1'b0;
    chk("t033_rst_cnt", match_count, 0);
    chk("t033_rst_armed", armed, 0);
    seq("t033b", 3, 16'b101, 16'b001);
    do_reset();
    seq("t034a", 2, 16'b10, 16'b00);
    for (int i = 0; i < 3; i++) begin
      step(i[0] ? 1'b0 : 1'b1, 1'b0);
      chk("t034_hold_out", out, 0);
    end
    step(1'b1, 1'b1);
    chk("t034_out", out, 1);
    step(1'b1, 1'b0);
    chk("t034_after", out, 0);
    do_reset();
    load(8'b11, 4'd2, 1'b1);
    pulses = 0;
    for (int i = 0; i < 6; i++) begin
      step(1'b1, 1'b1);
      pulses += int'(out_s);
    end
    chk("t035_pulses", pulses, 5);
    chk("t035_cnt_sat", cnt_s, 3);
    chk("t035_cnt_wide", match_count, 5);
    chk("t035_armed", armed_s, 1);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
